// File: rtl/exc_report.sv
// -----------------------------------------------------------------------------
// exc_report
//
// Exception-reporting front end that sits between the MEM stage and CP0.
// Each accepted MEM instruction is packed into the 14-bit excepttype bus:
//   [13:9] target CP0 register, [8] in_delayslot, [7] addr, [6] overflow,
//   [5] syscall, [4] break, [3] invalid_inst, [2] eret, [1] mfc0, [0] mtc0
// The bus is registered together with current_pc and rt_rdata. When an
// exception or eret is reported, the block runs a short sequence
// (REPORT -> FLUSH -> DRAIN) that captures CP0's redirect target and emits a
// one-cycle flush/redirect pulse.
//
// Optional feature macro: EXC_DELAYSLOT_EN
//   defined   : branch/jump in the previous accepted instruction marks the
//               current one as being in a delay slot (excepttype[8]).
//   undefined : excepttype[8] is tied to 0 and mem_is_branch is ignored.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   stall            MEM stage held, nothing is accepted
//   mem_valid        valid instruction in MEM
//   mem_pc           PC of the MEM instruction
//   mem_is_branch    MEM instruction is a branch/jump
//   mem_exc          {addr, overflow, syscall, break, invalid_inst}
//   mem_cp0_op       {eret, mfc0, mtc0}
//   mem_cp0_addr     CP0 register number
//   mem_rt_rdata     rt value for mtc0
//   excepttype       packed bus to CP0 (zero on non-accept cycles)
//   current_pc       PC to CP0 (holds between accepts)
//   rt_rdata         data to CP0 (holds between accepts)
//   cp0_new_pc       CP0 redirect target
//   cp0_flush        CP0 flush request
//   flush            kill all pipeline registers (1-cycle pulse)
//   redirect_valid   load redirect_pc into the fetch PC (1-cycle pulse)
//   redirect_pc      redirect target captured from CP0
//   busy             block not accepting; pipeline must stall
//   protocol_err     sticky; CP0 flush disagreed with what was reported
// -----------------------------------------------------------------------------
module exc_report (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_is_branch,
    input  logic [4:0]  mem_exc,
    input  logic [2:0]  mem_cp0_op,
    input  logic [4:0]  mem_cp0_addr,
    input  logic [31:0] mem_rt_rdata,
    output logic [13:0] excepttype,
    output logic [31:0] current_pc,
    output logic [31:0] rt_rdata,
    input  logic [31:0] cp0_new_pc,
    input  logic        cp0_flush,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic        protocol_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REPORT = 2'd1,
        S_FLUSH  = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        accept;
    logic        any_exc;
    logic [4:0]  exc_sel;
    logic        eret_sel, mtc0_sel, mfc0_sel;
    logic [4:0]  target_addr;
    logic        in_delayslot;
    logic [13:0] bus_d;
    logic        report_needed;

    logic [13:0] excepttype_q;
    logic [31:0] current_pc_q;
    logic [31:0] rt_rdata_q;
    logic [31:0] redirect_pc_q;
    logic        protocol_err_q;
    logic        bus_valid_q;     // a bus was accepted in the previous cycle
    logic        flush_d;
    logic        busy_d;
    logic        perr_set_d;

    assign accept  = mem_valid && !stall && (state_q == S_IDLE);
    assign any_exc = |mem_exc;

    // One-hot exception priority: a flag survives only if no higher-index
    // (higher-priority) flag is set.
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi = gi + 1) begin : g_exc_prio
            assign exc_sel[gi] = mem_exc[gi] & ~(|(mem_exc >> (gi + 1)));
        end
    endgenerate

    // CP0 operations are suppressed by any exception; eret > mtc0 > mfc0.
    assign eret_sel = !any_exc && mem_cp0_op[2];
    assign mtc0_sel = !any_exc && !mem_cp0_op[2] && mem_cp0_op[0];
    assign mfc0_sel = !any_exc && !mem_cp0_op[2] && !mem_cp0_op[0] && mem_cp0_op[1];

    assign target_addr   = (mtc0_sel || mfc0_sel) ? mem_cp0_addr : 5'd0;
    assign bus_d         = {target_addr, in_delayslot, exc_sel, eret_sel, mfc0_sel, mtc0_sel};
    assign report_needed = any_exc || mem_cp0_op[2];

`ifdef EXC_DELAYSLOT_EN
    logic prev_branch_q;

    // Remembers whether the last accepted instruction was a branch; a flush
    // discards that history since the pipeline restarts at a new target.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_branch_q <= 1'b0;
        end else if (accept) begin
            prev_branch_q <= mem_is_branch;
        end else if (state_q == S_FLUSH) begin
            prev_branch_q <= 1'b0;
        end
    end

    assign in_delayslot = prev_branch_q;
`else
    logic unused_is_branch;
    assign unused_is_branch = mem_is_branch;
    assign in_delayslot     = 1'b0;
`endif

    // Next-state and control decode
    always_comb begin
        state_d    = state_q;
        flush_d    = 1'b0;
        busy_d     = 1'b1;
        perr_set_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                // Only non-reporting buses stay in IDLE; CP0 must not flush them.
                if (bus_valid_q && cp0_flush) begin
                    perr_set_d = 1'b1;
                end
                if (accept && report_needed) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                if (!cp0_flush) begin
                    perr_set_d = 1'b1;
                end
                state_d = S_FLUSH;
            end
            S_FLUSH: begin
                flush_d = 1'b1;
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            excepttype_q   <= 14'd0;
            current_pc_q   <= 32'd0;
            rt_rdata_q     <= 32'd0;
            redirect_pc_q  <= 32'd0;
            protocol_err_q <= 1'b0;
            bus_valid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_valid_q <= accept;
            if (accept) begin
                excepttype_q <= bus_d;
                current_pc_q <= mem_pc;
                rt_rdata_q   <= mem_rt_rdata;
            end else begin
                // Zero on idle cycles so CP0 never sees a repeated operation.
                excepttype_q <= 14'd0;
            end
            if (state_q == S_REPORT) begin
                redirect_pc_q <= cp0_new_pc;
            end
            if (perr_set_d) begin
                protocol_err_q <= 1'b1;
            end
        end
    end

    assign excepttype     = excepttype_q;
    assign current_pc     = current_pc_q;
    assign rt_rdata       = rt_rdata_q;
    assign redirect_pc    = redirect_pc_q;
    assign protocol_err   = protocol_err_q;
    assign flush          = flush_d;
    assign redirect_valid = flush_d;
    assign busy           = busy_d;

endmodule

// File: tb/tb_exc_report.sv
// -----------------------------------------------------------------------------
// tb_exc_report
//
// Scoreboard bench for exc_report. A driver task applies one cycle of
// stimulus, advances a reference model of the reporting sequence and pushes
// the expected bus / redirect target into queues. An independent monitor
// on the falling edge pops and compares whenever the DUT presents a non-zero
// bus or a flush pulse, and checks busy/flush/protocol_err every cycle.
// -----------------------------------------------------------------------------
module tb_exc_report;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_pc = 32'd0;
    logic        mem_is_branch = 1'b0;
    logic [4:0]  mem_exc = 5'd0;
    logic [2:0]  mem_cp0_op = 3'd0;
    logic [4:0]  mem_cp0_addr = 5'd0;
    logic [31:0] mem_rt_rdata = 32'd0;
    logic [31:0] cp0_new_pc = 32'd0;
    logic        cp0_flush = 1'b0;
    logic [13:0] excepttype;
    logic [31:0] current_pc;
    logic [31:0] rt_rdata;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic        protocol_err;

    exc_report dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .mem_valid      (mem_valid),
        .mem_pc         (mem_pc),
        .mem_is_branch  (mem_is_branch),
        .mem_exc        (mem_exc),
        .mem_cp0_op     (mem_cp0_op),
        .mem_cp0_addr   (mem_cp0_addr),
        .mem_rt_rdata   (mem_rt_rdata),
        .excepttype     (excepttype),
        .current_pc     (current_pc),
        .rt_rdata       (rt_rdata),
        .cp0_new_pc     (cp0_new_pc),
        .cp0_flush      (cp0_flush),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .protocol_err   (protocol_err)
    );

    int checks = 0;
    int errors = 0;

    logic [77:0] sb_q[$];     // {excepttype, current_pc, rt_rdata}
    logic [31:0] redir_q[$];  // expected redirect_pc at each flush pulse

    // Reference model: ph counts cycles since a reporting accept
    // (0 idle, 1 bus at CP0, 2 flush pulse, 3 drain).
    int ph = 0;
    bit m_prev_br = 1'b0;
    bit m_perr = 1'b0;
    bit m_last_acc = 1'b0;
    bit exp_busy = 1'b0;
    bit exp_flush = 1'b0;
    bit exp_perr = 1'b0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [77:0] act, input logic [77:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected bus from the reporting rules: highest set exception wins and
    // silences CP0 ops; otherwise eret, then mtc0, then mfc0.
    function automatic logic [13:0] ref_bus(input logic [4:0] ex, input logic [2:0] op,
                                            input logic [4:0] ad, input bit pb);
        logic [13:0] b;
        int top;
        b   = 14'd0;
        top = -1;
        for (int i = 0; i < 5; i++) begin
            if (ex[i]) top = i;
        end
        if (top >= 0) begin
            b[3 + top] = 1'b1;
        end else if (op[2]) begin
            b[2] = 1'b1;
        end else if (op[0]) begin
            b[0]    = 1'b1;
            b[13:9] = ad;
        end else if (op[1]) begin
            b[1]    = 1'b1;
            b[13:9] = ad;
        end
`ifdef EXC_DELAYSLOT_EN
        b[8] = pb;
`else
        b[8] = 1'b0;
        if (pb) b[8] = 1'b0;
`endif
        return b;
    endfunction

    // One cycle of stimulus; bad inverts the CP0 flush answer the model expects.
    task automatic drive(input bit v, input bit st, input logic [31:0] pc, input bit br,
                         input logic [4:0] ex, input logic [2:0] op, input logic [4:0] ad,
                         input logic [31:0] rt, input bit bad, input logic [31:0] npc,
                         input bit r);
        logic [13:0] b;
        bit acc;
        @(posedge clk);
        #1;
        rst           = r;
        mem_valid     = v;
        stall         = st;
        mem_pc        = pc;
        mem_is_branch = br;
        mem_exc       = ex;
        mem_cp0_op    = op;
        mem_cp0_addr  = ad;
        mem_rt_rdata  = rt;
        cp0_flush     = (ph == 1) ^ bad;
        cp0_new_pc    = npc;
        exp_busy      = (ph != 0);
        exp_flush     = (ph == 2);
        exp_perr      = m_perr;
        acc = v && !st && (ph == 0) && !r;
        b   = ref_bus(ex, op, ad, m_prev_br);
        if (r) begin
            ph         = 0;
            m_prev_br  = 1'b0;
            m_perr     = 1'b0;
            m_last_acc = 1'b0;
        end else begin
            if (ph == 1 && !cp0_flush) m_perr = 1'b1;
            if (ph == 0 && m_last_acc && cp0_flush) m_perr = 1'b1;
            if (ph == 1) redir_q.push_back(npc);
            if (ph == 2) m_prev_br = 1'b0;
            if (acc) begin
                if (b != 14'd0) sb_q.push_back({b, pc, rt});
                m_prev_br = br;
            end
            m_last_acc = acc;
            if (acc && (ex != 5'd0 || op[2])) ph = 1;
            else if (ph == 3) ph = 0;
            else if (ph != 0) ph = ph + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 0, 32'd0, 0, 5'd0, 3'd0, 5'd0, 32'd0, 0, $urandom, 0);
        end
    endtask

    // Monitor: decoupled from the driver, compares on the falling edge.
    always @(negedge clk) begin : monitor
        logic [77:0] e;
        logic [31:0] rp;
        if (mon_en) begin
            chk("busy", busy, exp_busy);
            chk("flush", flush, exp_flush);
            chk("redirect_valid", redirect_valid, exp_flush);
            chk("protocol_err", protocol_err, exp_perr);
            if (excepttype != 14'd0) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_bus", excepttype, 0);
                end else begin
                    e = sb_q.pop_front();
                    $display("txn bus=%h pc=%h rt=%h", excepttype, current_pc, rt_rdata);
                    chk("bus", {excepttype, current_pc, rt_rdata}, e);
                end
            end
            if (flush) begin
                if (redir_q.size() == 0) begin
                    chk("unexpected_flush", flush, 0);
                end else begin
                    rp = redir_q.pop_front();
                    $display("txn flush redirect_pc=%h", redirect_pc);
                    chk("redirect_pc", redirect_pc, rp);
                end
            end
        end
    end

    initial begin
        logic [4:0] rex;
        // Reset, then idle
        drive(0, 0, 32'd0, 0, 5'd0, 3'd0, 5'd0, 32'd0, 0, 32'd0, 1);
        drive(0, 0, 32'd0, 0, 5'd0, 3'd0, 5'd0, 32'd0, 0, 32'd0, 1);
        mon_en = 1'b1;
        idle(3);
        @(negedge clk);
        chk("rst_excepttype", excepttype, 0);
        chk("rst_current_pc", current_pc, 0);
        chk("rst_rt_rdata", rt_rdata, 0);
        chk("rst_redirect_pc", redirect_pc, 0);

        // mtc0 to register 12
        drive(1, 0, 32'hBFC0_0100, 0, 5'd0, 3'b001, 5'd12, 32'h0000_0001, 0, 32'd0, 0);
        idle(1);
        @(negedge clk);
        chk("mtc0_bus", excepttype, 14'h1801);
        chk("mtc0_rt", rt_rdata, 32'h1);
        idle(1);
        @(negedge clk);
        chk("mtc0_bus_cleared", excepttype, 0);
        chk("mtc0_no_flush", flush, 0);

        // addr + overflow: addr wins, full flush sequence
        drive(1, 0, 32'hBFC0_0200, 0, 5'b11000, 3'd0, 5'd0, 32'd0, 0, 32'd0, 0);
        drive(0, 0, 32'd0, 0, 5'd0, 3'd0, 5'd0, 32'd0, 0, 32'hBFC0_0380, 0);
        @(negedge clk);
        chk("exc_bus", excepttype, 14'h0080);
        chk("exc_busy", busy, 1);
        idle(1);
        @(negedge clk);
        chk("exc_flush", flush, 1);
        chk("exc_redirect_pc", redirect_pc, 32'hBFC0_0380);
        idle(2);
        @(negedge clk);
        chk("exc_back_idle", busy, 0);

        // Branch then syscall back to back
        drive(1, 0, 32'h0000_0100, 1, 5'd0, 3'd0, 5'd0, 32'd0, 0, 32'd0, 0);
        drive(1, 0, 32'h0000_0104, 0, 5'b00100, 3'd0, 5'd0, 32'd0, 0, 32'd0, 0);
        idle(1);
        @(negedge clk);
`ifdef EXC_DELAYSLOT_EN
        chk("delayslot_bus", excepttype, 14'h0120);
`else
        chk("delayslot_bus", excepttype, 14'h0020);
`endif
        idle(3);

        // eret with break: eret dropped
        drive(1, 0, 32'h0000_0200, 0, 5'b00010, 3'b100, 5'd0, 32'd0, 0, 32'd0, 0);
        idle(1);
        @(negedge clk);
        chk("eret_break_bus", excepttype, 14'h0010);
        idle(3);

        // eret alone, CP0 refuses to flush
        drive(1, 0, 32'h0000_0300, 0, 5'd0, 3'b100, 5'd0, 32'd0, 0, 32'd0, 0);
        drive(0, 0, 32'd0, 0, 5'd0, 3'd0, 5'd0, 32'd0, 1, 32'h8000_0180, 0);
        idle(1);
        @(negedge clk);
        chk("perr_set", protocol_err, 1);
        idle(4);
        @(negedge clk);
        chk("perr_sticky", protocol_err, 1);
        drive(0, 0, 32'd0, 0, 5'd0, 3'd0, 5'd0, 32'd0, 0, 32'd0, 1);
        idle(1);
        @(negedge clk);
        chk("perr_cleared", protocol_err, 0);

        // Reset during FLUSH
        drive(1, 0, 32'h0000_0400, 0, 5'b00001, 3'd0, 5'd0, 32'd0, 0, 32'd0, 0);
        idle(1);
        drive(0, 0, 32'd0, 0, 5'd0, 3'd0, 5'd0, 32'd0, 0, 32'd0, 1);
        idle(1);
        @(negedge clk);
        chk("rst_flush_busy", busy, 0);
        chk("rst_flush_flush", flush, 0);
        chk("rst_flush_rv", redirect_valid, 0);

        // Unexpected flush after a plain mtc0
        drive(1, 0, 32'h0000_0500, 0, 5'd0, 3'b001, 5'd3, 32'h55, 0, 32'd0, 0);
        drive(0, 0, 32'd0, 0, 5'd0, 3'd0, 5'd0, 32'd0, 1, 32'd0, 0);
        idle(1);
        @(negedge clk);
        chk("perr_idle", protocol_err, 1);
        drive(0, 0, 32'd0, 0, 5'd0, 3'd0, 5'd0, 32'd0, 0, 32'd0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rex = ($urandom % 3 == 0) ? 5'($urandom) : 5'd0;
            drive(($urandom % 4) != 0, ($urandom % 5) == 0, $urandom, 1'($urandom),
                  rex, 3'($urandom), 5'($urandom), $urandom, 0, $urandom, 0);
        end
        idle(5);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("sb_drained", sb_q.size(), 0);
        chk("redir_drained", redir_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
